// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_add_ctrl : bit-serial adder, one shared full_adder over WIDTH bits   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_next;

  logic accept;
  logic last_bit;

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Partial sum keeps only the bits that survive the next shift; bit 0 of the
  // shifted word would fall off and is never stored.
  generate
    if (WIDTH > 1) begin : g_wide
      logic [WIDTH-2:0] sum_sh;

      assign sum_next = {fa_s, sum_sh};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_sh <= '0;
        end else if (accept) begin
          sum_sh <= '0;
        end else if (state == RUN) begin
          sum_sh <= sum_next[WIDTH-1:1];
        end
      end
    end else begin : g_narrow
      assign sum_next = fa_s;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= fa_co;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum   <= sum_next;
            cout  <= fa_co;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);

endmodule
`default_nettype wire
